// File: rtl/ram_read_arbiter.sv
// Round-robin arbiter sharing one RAM read port among NUM_REQ requesters.
// A tag pipeline matched to the RAM read latency routes each returned word back to its issuer.
module ram_read_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 32,
    parameter int READ_LATENCY = 2,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [WIDTH-1:0]          resp_data,
    output logic                      mem_read,
    output logic [ADDR_W-1:0]         mem_addrb,
    input  logic [WIDTH-1:0]          mem_doutb,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    // Handshake: request i is accepted in any cycle where req_valid[i] && req_ready[i];
    // the grant is same-cycle, so an unserved request is simply retried next cycle.
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win;
    logic [PTR_W:0]    cand;
    logic              any;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0] addr_sel;

    logic [READ_LATENCY-1:0] tag_valid;
    logic [NUM_REQ-1:0]      tag_id [READ_LATENCY];

    assign any = rst_n & (|req_valid);

    // Descending scan so the offset closest to the pointer is the last one to win.
    always_comb begin
        win  = '0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (req_valid[cand[PTR_W-1:0]]) begin
                win = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        grant    = '0;
        addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = any && (win == PTR_W'(i));
            if (grant[i]) begin
                addr_sel = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign req_ready = grant;
    assign mem_read  = any;
    assign mem_addrb = addr_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (any) begin
            ptr <= (win == LAST_IDX) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid[0] <= any;
            tag_id[0]    <= grant;
            for (int s = 1; s < READ_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    // The RAM output is already registered, so the data bus is passed straight through.
    assign resp_valid = tag_valid[READ_LATENCY-1] ? tag_id[READ_LATENCY-1] : '0;
    assign resp_data  = mem_doutb;
    assign busy       = |tag_valid;

endmodule

// File: doc/ram_read_arbiter.md
Name: ram_read_arbiter

Overview:
- Shares the single read port of one simple dual-port RAM instance (fixed READ_LATENCY, no output backpressure) among NUM_REQ requesters.
- Arbitrates round-robin, issues at most one read per cycle and tracks the in-flight reads in a tag pipeline.
- Routes each returning word to the requester that issued it.
- Sits between compute lanes and a shared lookup/coefficient RAM; the RAM write port is not touched.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, RAM data width
DEPTH, 32, RAM depth in words; ADDR_W = $clog2(DEPTH) (derived, not overridable)
READ_LATENCY, 2, cycles from mem_read asserted to valid mem_doutb (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_ready  out  NUM_REQ  one-hot grant; request i accepted in cycles where req_valid[i] && req_ready[i]
resp_valid  out  NUM_REQ  one-hot; resp_data belongs to requester i this cycle
resp_data  out  WIDTH  returned word, shared bus
mem_read  out  1  RAM read enable (port B)
mem_addrb  out  ADDR_W  RAM read address
mem_doutb  in  WIDTH  RAM read data
busy  out  1  high while any read is in flight

Behaviour:
- Reset (async assert, sync release):
  - round-robin pointer = 0; tag pipeline cleared.
  - resp_valid = 0, busy = 0.
  - req_ready, mem_read, mem_addrb are combinational; they are 0 while rst_n is low.
- Arbitration (combinational):
  - Winner = first i with req_valid[i], searching from the pointer upward and wrapping modulo NUM_REQ.
  - req_ready = one-hot of the winner; 0 if no request is valid.
  - req_ready[i] never depends on req_ready of other requesters.
- Issue (same cycle as grant):
  - mem_read = |req_valid.
  - mem_addrb = req_addr of the winner; 0 when idle.
  - One read per cycle, so a full-rate request stream reaches 100% port utilisation.
- Pointer:
  - On a grant, the pointer becomes winner+1 (wraps NUM_REQ-1 -> 0).
  - With no grant the pointer holds.
  - Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Requester rule: req_valid/req_addr may change freely; there is no hold requirement because grant is same-cycle. A request not granted is simply retried next cycle.
- Tag pipeline:
  - READ_LATENCY stages, each holding {valid, one-hot id}.
  - Stage 0 is loaded with {mem_read, req_ready}; the pipeline shifts every cycle.
  - resp_valid = last stage id gated by last stage valid.
  - resp_data = mem_doutb passed through combinationally. It is the final RAM output register, so no extra register is added.
- Response timing: a request granted in cycle t yields resp_valid[i]=1 in cycle t+READ_LATENCY.
  - Responses are in issue order.
  - Responses cannot be stalled; requesters must sink them.
- busy = OR of all stage valids.
- Boundaries:
  - Back-to-back grants to the same requester are allowed when it is the only one valid; consecutive responses follow.
  - All requesters valid: grants rotate 0,1,2,3,0...
  - Reset mid-flight: all in-flight tags are dropped and no resp_valid appears afterwards, even though the RAM still returns data.
  - Address out of range (>= DEPTH when DEPTH is not a power of 2): passed through unchanged; RAM behaviour applies.

Test Plan:
1. Reset release, all req_valid=0 for 10 cycles -> req_ready=0, mem_read=0, resp_valid=0, busy=0 throughout.
2. Single requester 2 at addr 5 (RAM[5]=0xA5), cycle t -> req_ready=4'b0100 and mem_addrb=5 at t; resp_valid=4'b0100 and resp_data=0xA5 at t+2; busy high at t+1 and t+2.
3. All four valid for 8 cycles, addresses i+10, RAM[k]=k -> grants 0,1,2,3,0,1,2,3; responses two cycles later carry ids in the same order with data 10,11,12,13 repeated.
4. Requester 1 continuously valid, requester 3 toggles valid every other cycle -> requester 3 is granted within 2 cycles of each assertion; requester 1 is granted all remaining cycles; no cycle without mem_read.
5. Grant requester 0 at t, assert rst_n=0 at t+1 for one cycle -> no resp_valid at t+2; pointer=0 after release; next request from requester 1 is served normally.
6. Parameter sweep NUM_REQ=3, READ_LATENCY=3: a request at t returns at t+3; the pointer wraps 2 -> 0.
